sr_latch_ctrl: RTL and testbench
================================

# sr_latch_ctrl

Synchronous controller that shares one cross-coupled NOR SR latch between `N_REQ` requesters. It turns per-requester set/clear requests into clean, mutually exclusive `s`/`r` pulses with guaranteed width and recovery time, so the forbidden `s=r=1` input can never occur. It keeps a registered shadow of the latch value and can optionally read the latch back to check it. It sits between the lab's request logic and the latch primitive; the latch itself stays outside this block.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `PULSE_CYCLES`, 2: cycles `latch_s` or `latch_r` is held high per operation, ≥1.
- `GUARD_CYCLES`, 2: cycles with both latch inputs low after each pulse, ≥2.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  N_REQ  request per requester; held high until `ack`.
- `op`  in  N_REQ  per-requester operation: 1 = set, 0 = clear; stable while `req` is high.
- `ack`  out  N_REQ  one-hot, one-cycle completion pulse.
- `latch_s`  out  1  drives latch set input, registered.
- `latch_r`  out  1  drives latch reset input, registered.
- `latch_q`  in  1  latch output, asynchronous to `clk`.
- `shadow_q`  out  1  expected latch value.
- `busy`  out  1  high in any state except IDLE.
- `err`  out  1  sticky readback mismatch.

## Operation
- States: INIT, IDLE, DRIVE, GUARD, SKIP.
- Reset values: state=INIT; `latch_s`=`latch_r`=0; `ack`=0; `shadow_q`=0; `busy`=1; `err`=0; round-robin pointer=0.
- **INIT:** drive `latch_r` for `PULSE_CYCLES`, then go to GUARD. This forces the latch to 0.
- **IDLE:** if any `req` is high, grant one by round-robin, searching upward from the pointer with wrap-around. Then set pointer = grant+1 mod `N_REQ`.
  - If the granted `op` equals `shadow_q`, go to SKIP.
  - Otherwise go to DRIVE and latch the op.
- **DRIVE:** assert `latch_s` (set) or `latch_r` (clear) for `PULSE_CYCLES`. Update `shadow_q` on entry.
- **GUARD:** both latch inputs low for `GUARD_CYCLES`. `ack[grant]` pulses in the final GUARD cycle, except after INIT. Next state is IDLE.
- **SKIP:** `ack[grant]` pulses for one cycle with no latch activity. Next state is IDLE.
- Invariants:
  - `latch_s & latch_r` is never 1.
  - At most one `ack` bit is high at a time.
- Requests are sampled only in IDLE. A `req` that drops before its grant is ignored.
- A requester must drop `req` the cycle after `ack`. A `req` still high in IDLE counts as a new request.
- Asynchronous reset in any state aborts immediately. Outputs take their reset values, and INIT re-runs after `rst_n` is released.

## Timing
- Request seen in IDLE at cycle t. Latch input high during cycles t+1 .. t+`PULSE_CYCLES`. `ack` at t+`PULSE_CYCLES`+`GUARD_CYCLES`. IDLE again one cycle later.
- With defaults: `ack` at t+4, and the next grant is possible at t+5.
- SKIP path: `ack` at t+1, IDLE at t+2.
- After `rst_n` is released: `latch_r` high for the first `PULSE_CYCLES` cycles; IDLE reached after `PULSE_CYCLES`+`GUARD_CYCLES` cycles.
- Under contention, the worst-case wait for any requester is `N_REQ`−1 operations.

## Configuration
- `SR_LATCH_CTRL_VERIFY_EN`
  - **Defined:** `latch_q` passes through a 2-flop synchronizer. In the final GUARD cycle, including the one after INIT, the synchronized value is compared to `shadow_q`. A mismatch sets `err`, which stays high until reset. The `ack` still issues.
  - **Undefined:** no synchronizer, `err` tied to 0, and `latch_q` unused.

## Structure
- Shared package `sr_ctrl_pkg` holds:
  - state encoding constants (INIT=0, IDLE=1, DRIVE=2, GUARD=3, SKIP=4);
  - the OP_SET / OP_CLR constants;
  - a shared width helper for the pulse/guard counter.
- Sub-module `rr_arbiter`: parameterised `N_REQ` round-robin grant, with `req`, pointer, and `advance` inputs and a one-hot `grant` output.
- Top level contains the FSM, a single down-counter shared by DRIVE/GUARD/INIT, the shadow register, and the optional readback check.

## Test plan
- **Reset:** hold `rst_n` low, then release. Expect `latch_r` high for 2 cycles, `busy` low at cycle 4, `shadow_q`=0, `ack`=0 throughout.
- **Single set:** `req[1]`=1, `op[1]`=1 in IDLE at t. Expect `latch_s` high at t+1..t+2, `ack`=4'b0010 at t+4, `shadow_q`=1.
- **Redundant clear:** with `shadow_q`=0, `req[2]`=1, `op[2]`=0. Expect `ack[2]` at t+1 and no `latch_s`/`latch_r` activity.
- **Contention:** `req`=4'b1111 held, alternating ops, pointer 0. Expect grants in order 0,1,2,3,0 and `latch_s & latch_r` never 1.
- **Mid-operation reset:** assert `rst_n`=0 during DRIVE. Expect `latch_s`=0 immediately, INIT re-run after release, and the pending `ack` never issued.
- **Verify, with `SR_LATCH_CTRL_VERIFY_EN`:** a latch model stuck at 0, then a set request. Expect `err`=1 from the `ack` cycle until reset. Without the macro, `err`=0.

Source files
------------

// File: rtl/sr_latch_ctrl_pkg.sv
// Shared definitions for the SR latch controller: FSM encoding, operation codes
// and the width helper for the shared pulse/guard down-counter.
package sr_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_DRIVE = 3'd2,
        ST_GUARD = 3'd3,
        ST_SKIP  = 3'd4
    } state_t;

    localparam logic OP_SET = 1'b1;
    localparam logic OP_CLR = 1'b0;

    // The counter only ever holds (cycles - 1), so clog2 of the longer phase suffices.
    function automatic int cnt_width(input int pulse, input int guard);
        int m;
        m = (pulse > guard) ? pulse : guard;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/sr_latch_ctrl_if.sv
// Requester-side handshake bundle: per-requester req/op in, one-hot ack out.
interface sr_latch_ctrl_if #(
    parameter int N_REQ = 4
) ();
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] op;
    logic [N_REQ-1:0] ack;

    modport master (output req, output op, input ack);
    modport slave  (input req, input op, output ack);
endinterface

// File: rtl/sr_latch_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above the pointer,
// wrapping around; grant is one-hot and only produced while advance_i is high.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [PTR_W-1:0] ptr_i,
    input  logic             advance_i,
    output logic [N_REQ-1:0] grant_o
);
    int               j;
    logic [PTR_W-1:0] idx;
    logic             found;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        j       = 0;
        idx     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            j = int'(ptr_i) + k;
            if (j >= N_REQ) j = j - N_REQ;
            idx = PTR_W'(j);
            if (advance_i && !found && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end
endmodule

// File: rtl/sr_latch_ctrl.sv
// Shares one NOR SR latch between N_REQ requesters with non-overlapping s/r pulses.
// Optional readback check of latch_q is enabled by defining SR_LATCH_CTRL_VERIFY_EN.
module sr_latch_ctrl
    import sr_ctrl_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int PULSE_CYCLES = 2,
    parameter int GUARD_CYCLES = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    sr_latch_ctrl_if.slave bus,
    output logic           latch_s,
    output logic           latch_r,
    input  logic           latch_q,
    output logic           shadow_q,
    output logic           busy,
    output logic           err
);
    localparam int PTR_W = (N_REQ > 2) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = cnt_width(PULSE_CYCLES, GUARD_CYCLES);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [N_REQ-1:0] grant_d, grant_q, ack_q;
    logic             latch_s_q, latch_r_q, sh_q, busy_q, err_q;
    logic             op_d, chk_fail_d;

    rr_arbiter #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_arb (
        .req_i    (bus.req),
        .ptr_i    (ptr_q),
        .advance_i(state_q == ST_IDLE),
        .grant_o  (grant_d)
    );

    always_comb begin
        ptr_d = ptr_q;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_d[i]) ptr_d = (i == N_REQ - 1) ? '0 : PTR_W'(i + 1);
        end
    end

    assign op_d = |(grant_d & bus.op);

`ifdef SR_LATCH_CTRL_VERIFY_EN
    logic sync1_q, sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= latch_q;
            sync2_q <= sync1_q;
        end
    end

    assign chk_fail_d = (sync2_q != sh_q);
`else
    wire unused_latch_q = latch_q;
    assign chk_fail_d = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_INIT;
            cnt_q     <= '0;
            ptr_q     <= '0;
            grant_q   <= '0;
            ack_q     <= '0;
            latch_s_q <= 1'b0;
            latch_r_q <= 1'b0;
            sh_q      <= 1'b0;
            busy_q    <= 1'b1;
            err_q     <= 1'b0;
        end else begin
            ack_q <= '0;
            case (state_q)
                // latch_r_q doubles as the "INIT pulse already started" flag
                ST_INIT: begin
                    if (!latch_r_q) begin
                        latch_r_q <= 1'b1;
                        cnt_q     <= CNT_W'(PULSE_CYCLES - 1);
                    end else if (cnt_q == '0) begin
                        latch_r_q <= 1'b0;
                        cnt_q     <= CNT_W'(GUARD_CYCLES - 1);
                        state_q   <= ST_GUARD;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (|grant_d) begin
                        grant_q <= grant_d;
                        ptr_q   <= ptr_d;
                        busy_q  <= 1'b1;
                        if (op_d == sh_q) begin
                            ack_q   <= grant_d;
                            state_q <= ST_SKIP;
                        end else begin
                            sh_q      <= op_d;
                            latch_s_q <= (op_d == OP_SET);
                            latch_r_q <= (op_d == OP_CLR);
                            cnt_q     <= CNT_W'(PULSE_CYCLES - 1);
                            state_q   <= ST_DRIVE;
                        end
                    end
                end
                ST_DRIVE: begin
                    if (cnt_q == '0) begin
                        latch_s_q <= 1'b0;
                        latch_r_q <= 1'b0;
                        cnt_q     <= CNT_W'(GUARD_CYCLES - 1);
                        state_q   <= ST_GUARD;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                // grant_q is still zero after INIT, so that final GUARD cycle acks nobody
                ST_GUARD: begin
                    if (cnt_q == CNT_W'(1)) begin
                        ack_q <= grant_q;
                        if (chk_fail_d) err_q <= 1'b1;
                    end
                    if (cnt_q == '0) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_SKIP: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_INIT;
            endcase
        end
    end

    assign bus.ack  = ack_q;
    assign latch_s  = latch_s_q;
    assign latch_r  = latch_r_q;
    assign shadow_q = sh_q;
    assign busy     = busy_q;
    assign err      = err_q;
endmodule

// File: tb/tb_sr_latch_ctrl.sv
// Bench for sr_latch_ctrl: directed scenarios plus random requesters, checked every
// cycle against a timeline model built from the operation/timing rules.
module tb_sr_latch_ctrl;
    localparam int N    = 4;
    localparam int P    = 2;
    localparam int G    = 2;
    localparam int MAXC = 4096;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic latch_s, latch_r, shadow_q, busy, err;
    logic latch_q = 1'b0;
    logic [N-1:0] req_v = '0;
    logic [N-1:0] op_v = '0;

    sr_latch_ctrl_if #(.N_REQ(N)) bus ();
    assign bus.req = req_v;
    assign bus.op  = op_v;

    sr_latch_ctrl #(.N_REQ(N), .PULSE_CYCLES(P), .GUARD_CYCLES(G)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .latch_s (latch_s),
        .latch_r (latch_r),
        .latch_q (latch_q),
        .shadow_q(shadow_q),
        .busy    (busy),
        .err     (err)
    );

    always #5 clk = ~clk;

    bit stuck = 1'b0;
    always @(latch_s or latch_r or stuck) begin
        if (stuck) latch_q = 1'b0;
        else if (latch_s && !latch_r) latch_q = 1'b1;
        else if (latch_r && !latch_s) latch_q = 1'b0;
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit in_reset = 1'b1;
    bit hold_all = 1'b0;

    // expected outputs per cycle index
    logic         e_s    [MAXC];
    logic         e_r    [MAXC];
    logic         e_busy [MAXC];
    logic         e_sh   [MAXC];
    logic [N-1:0] e_ack  [MAXC];

    int   idle_from = MAXC;
    int   ptr = 0;
    logic sh = 1'b0;
    int   err_from = 2 * MAXC;
    int   drop_at [N];
    bit   granted [N];
    int   ack_log [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic put(input int c, input logic s, input logic r, input logic [N-1:0] a,
                       input logic b, input logic h);
        if (c < MAXC) begin
            e_s[c] = s; e_r[c] = r; e_ack[c] = a; e_busy[c] = b; e_sh[c] = h;
        end
    endtask

    task automatic model_reset(input int c0);
        for (int k = 0; k < P; k++) put(c0 + k, 1'b0, 1'b1, '0, 1'b1, 1'b0);
        for (int k = 0; k < G; k++) put(c0 + P + k, 1'b0, 1'b0, '0, 1'b1, 1'b0);
        put(c0 + P + G, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        idle_from = c0 + P + G;
        ptr = 0;
        sh = 1'b0;
        err_from = 2 * MAXC;
        for (int i = 0; i < N; i++) begin
            drop_at[i] = -1;
            granted[i] = 1'b0;
        end
    endtask

    task automatic model_step(input int t);
        int g;
        logic [N-1:0] one_g;
        if (t < idle_from) return;
        g = -1;
        for (int k = 0; k < N; k++) begin
            if (g < 0 && req_v[(ptr + k) % N]) g = (ptr + k) % N;
        end
        if (g < 0) begin
            put(t + 1, 1'b0, 1'b0, '0, 1'b0, sh);
            idle_from = t + 1;
            return;
        end
        one_g = '0;
        one_g[g] = 1'b1;
        ptr = (g + 1) % N;
        granted[g] = 1'b1;
        if (op_v[g] == sh) begin
            put(t + 1, 1'b0, 1'b0, one_g, 1'b1, sh);
            put(t + 2, 1'b0, 1'b0, '0, 1'b0, sh);
            idle_from = t + 2;
            drop_at[g] = t + 2;
        end else begin
            sh = op_v[g];
            for (int k = 1; k <= P; k++) put(t + k, sh, !sh, '0, 1'b1, sh);
            for (int k = 1; k <= G; k++) put(t + P + k, 1'b0, 1'b0, (k == G) ? one_g : '0, 1'b1, sh);
            put(t + P + G + 1, 1'b0, 1'b0, '0, 1'b0, sh);
            idle_from = t + P + G + 1;
            drop_at[g] = t + P + G + 1;
            if (stuck && sh && (t + P + G < err_from)) err_from = t + P + G;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        if (in_reset) begin
            check_eq("rst_latch_s", latch_s, 0);
            check_eq("rst_latch_r", latch_r, 0);
            check_eq("rst_ack", bus.ack, 0);
            check_eq("rst_shadow", shadow_q, 0);
            check_eq("rst_busy", busy, 1);
            check_eq("rst_err", err, 0);
        end else begin
            check_eq("latch_s", latch_s, e_s[cyc]);
            check_eq("latch_r", latch_r, e_r[cyc]);
            check_eq("ack", bus.ack, e_ack[cyc]);
            check_eq("busy", busy, e_busy[cyc]);
            check_eq("shadow", shadow_q, e_sh[cyc]);
            check_eq("err", err, (cyc >= err_from) ? 1 : 0);
        end
        check_eq("s_and_r", latch_s & latch_r, 0);
        check_eq("ack_onehot", ($countones(bus.ack) > 1) ? 1 : 0, 0);
        for (int i = 0; i < N; i++) if (bus.ack[i]) ack_log.push_back(i);
    endtask

    task automatic apply_stim(input bit rnd);
        for (int i = 0; i < N; i++) begin
            if (drop_at[i] == cyc) begin
                drop_at[i] = -1;
                granted[i] = 1'b0;
                if (!hold_all) req_v[i] = 1'b0;
            end else if (rnd) begin
                if (!req_v[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        req_v[i] = 1'b1;
                        op_v[i]  = 1'($urandom_range(0, 1));
                    end
                end else if (!granted[i] && $urandom_range(0, 15) == 0) begin
                    req_v[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic run(input int n, input bit rnd);
        for (int k = 0; k < n; k++) begin
            tick();
            apply_stim(rnd);
            model_step(cyc);
        end
    endtask

    // returns inside an IDLE cycle, before that cycle's requests are sampled
    task automatic run_until_idle();
        for (int k = 0; k < 60; k++) begin
            tick();
            apply_stim(1'b0);
            if (cyc >= idle_from) return;
            model_step(cyc);
        end
        check_eq("idle_timeout", 0, 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_eq("async_latch_s", latch_s, 0);
        check_eq("async_latch_r", latch_r, 0);
        check_eq("async_busy", busy, 1);
        check_eq("async_ack", bus.ack, 0);
        req_v = '0;
        in_reset = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        in_reset = 1'b0;
        model_reset(cyc + 1);
    endtask

    initial begin
        int exp_order [5] = '{0, 1, 2, 3, 0};
        tick(); tick(); tick();
        rst_n = 1'b1;
        in_reset = 1'b0;
        model_reset(cyc + 1);

        // redundant clear while shadow is 0
        run_until_idle();
        req_v[2] = 1'b1; op_v[2] = 1'b0;
        model_step(cyc);
        run(4, 1'b0);

        // single set
        run_until_idle();
        req_v[1] = 1'b1; op_v[1] = 1'b1;
        model_step(cyc);
        run(7, 1'b0);

        // clear back to 0, then reset in the middle of a set pulse
        run_until_idle();
        req_v[0] = 1'b1; op_v[0] = 1'b0;
        model_step(cyc);
        run_until_idle();
        req_v[3] = 1'b1; op_v[3] = 1'b1;
        model_step(cyc);
        tick();
        do_reset();

        // contention with all requests held, pointer freshly reset
        run_until_idle();
        hold_all = 1'b1;
        req_v = 4'b1111;
        op_v  = 4'b1010;
        ack_log.delete();
        model_step(cyc);
        for (int k = 0; k < 80 && ack_log.size() < 5; k++) begin
            tick();
            apply_stim(1'b0);
            model_step(cyc);
        end
        check_eq("order_cnt", (ack_log.size() >= 5) ? 1 : 0, 1);
        for (int k = 0; k < 5 && k < ack_log.size(); k++) check_eq("order", ack_log[k], exp_order[k]);
        hold_all = 1'b0;
        req_v = '0;
        for (int i = 0; i < N; i++) begin
            granted[i] = 1'b0;
            drop_at[i] = -1;
        end
        run(4, 1'b0);

        run(1500, 1'b1);
        for (int i = 0; i < N; i++) if (!granted[i]) req_v[i] = 1'b0;
        run_until_idle();

`ifdef SR_LATCH_CTRL_VERIFY_EN
        stuck = 1'b1;
        if (sh) begin
            req_v[0] = 1'b1; op_v[0] = 1'b0;
            model_step(cyc);
            run_until_idle();
        end
        req_v[1] = 1'b1; op_v[1] = 1'b1;
        model_step(cyc);
        run(10, 1'b0);
        check_eq("err_sticky", err, 1);
        do_reset();
        run(8, 1'b0);
`else
        model_step(cyc);
        run(8, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
        $fatal(1);
    end
endmodule
